// File: rtl/m68k_bus_master.sv
// 68000-style asynchronous bus master: arbitrates for the bus with BR/BG/BGACK,
// runs one read or write cycle per local request and reports done or err.
module m68k_bus_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter bit          KEEP_BUS = 1'b1
) (
  input  logic        clk,
  input  logic        por_n,
  // local request side
  input  logic        req,
  input  logic        req_rw,
  input  logic [22:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  // arbitration
  output logic        br_n,
  output logic        bgack_n,
  input  logic        bg_n,
  input  logic        bgack_in_n,
  input  logic        as_in_n,
  // bus cycle
  output logic        as_n,
  output logic        uds_n,
  output logic        lds_n,
  output logic        rw,
  output logic [22:0] addr_out,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] data_in,
  input  logic        dtack_n,
  input  logic        berr_n,
  output logic        bus_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_OWN, S_ADDR, S_STRB, S_WAIT, S_END, S_REL
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_rw;
  logic [1:0]  r_be;
  logic [7:0]  r_cnt;
  logic        r_err;

  logic w_be_ok;
  logic w_grant;
  logic w_dtack;
  logic w_berr;
  logic w_tmo;
  logic w_keep;
  logic w_load;

  assign w_be_ok = |req_be;
  // The bus is free only when the CPU grants it and no other cycle or master is active.
  assign w_grant = !bg_n && as_in_n && dtack_n && bgack_in_n;
  assign w_dtack = !dtack_n;
  assign w_berr  = !berr_n;
  assign w_tmo   = (r_cnt >= TMO_LAST);
  assign w_keep  = KEEP_BUS && req && w_be_ok && !r_err;
  assign w_load  = ((r_state == S_IDLE) && req && w_be_ok) ||
                   ((r_state == S_END) && w_keep);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (req && w_be_ok) w_next = S_REQ;
      S_REQ:  if (w_grant) w_next = S_OWN;
      S_OWN:  w_next = S_ADDR;
      S_ADDR: w_next = S_STRB;
      S_STRB: w_next = S_WAIT;
      S_WAIT: if (w_berr || w_dtack || w_tmo) w_next = S_END;
      S_END:  w_next = w_keep ? S_ADDR : S_REL;
      S_REL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    br_n    = 1'b1;
    bgack_n = 1'b1;
    bus_oe  = 1'b0;
    as_n    = 1'b1;
    uds_n   = 1'b1;
    lds_n   = 1'b1;
    rw      = 1'b1;
    data_oe = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (r_state)
      S_IDLE: err = por_n && req && !w_be_ok;
      S_REQ:  br_n = 1'b0;
      S_OWN: begin
        bgack_n = 1'b0;
        bus_oe  = 1'b1;
      end
      S_ADDR: begin
        bgack_n = 1'b0;
        bus_oe  = 1'b1;
        rw      = r_rw;
        data_oe = !r_rw;
      end
      S_STRB: begin
        bgack_n = 1'b0;
        bus_oe  = 1'b1;
        rw      = r_rw;
        data_oe = !r_rw;
        as_n    = 1'b0;
        // Reads strobe the data lanes with AS; writes wait one clock for data setup.
        uds_n   = !(r_rw && r_be[1]);
        lds_n   = !(r_rw && r_be[0]);
      end
      S_WAIT: begin
        bgack_n = 1'b0;
        bus_oe  = 1'b1;
        rw      = r_rw;
        data_oe = !r_rw;
        as_n    = 1'b0;
        uds_n   = !r_be[1];
        lds_n   = !r_be[0];
      end
      S_END: begin
        bgack_n = 1'b0;
        bus_oe  = 1'b1;
        rw      = r_rw;
        data_oe = !r_rw;
        done    = !r_err;
        err     = r_err;
      end
      S_REL: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge por_n) begin
    if (!por_n) begin
      r_rw     <= 1'b1;
      r_be     <= 2'b00;
      addr_out <= '0;
      data_out <= '0;
      rdata    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_load) begin
        r_rw     <= req_rw;
        r_be     <= req_be;
        addr_out <= req_addr;
        data_out <= req_wdata;
      end

      if (r_state == S_STRB)
        r_cnt <= '0;
      else if ((r_state == S_WAIT) && (r_cnt != 8'hFF))
        r_cnt <= r_cnt + 8'd1;

      // Bus error wins over DTACK; DTACK wins over a timeout in the same clock.
      if (r_state == S_WAIT)
        r_err <= w_berr || (!w_dtack && w_tmo);

      if ((r_state == S_WAIT) && w_dtack && !w_berr && r_rw)
        rdata <= data_in;
    end
  end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master: read, write, bus error, timeout,
// back-to-back ownership and asynchronous reset, with hand-computed expectations.
module tb_m68k_bus_master;

  logic        clk = 1'b0;
  logic        por_n;
  logic        req;
  logic        req_rw;
  logic [22:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic        br_n;
  logic        bgack_n;
  logic        bg_n;
  logic        bgack_in_n;
  logic        as_in_n;
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        rw;
  logic [22:0] addr_out;
  logic [15:0] data_out;
  logic        data_oe;
  logic [15:0] data_in;
  logic        dtack_n;
  logic        berr_n;
  logic        bus_oe;

  int n_cmp = 0;
  int n_bad = 0;

  // Short timeout so the timeout path is reachable in a few clocks.
  m68k_bus_master #(.TIMEOUT(4), .KEEP_BUS(1'b1)) dut (
    .clk        (clk),
    .por_n      (por_n),
    .req        (req),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .br_n       (br_n),
    .bgack_n    (bgack_n),
    .bg_n       (bg_n),
    .bgack_in_n (bgack_in_n),
    .as_in_n    (as_in_n),
    .as_n       (as_n),
    .uds_n      (uds_n),
    .lds_n      (lds_n),
    .rw         (rw),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .data_oe    (data_oe),
    .data_in    (data_in),
    .dtack_n    (dtack_n),
    .berr_n     (berr_n),
    .bus_oe     (bus_oe)
  );

  always #5 clk = ~clk;

  // Event counters sampled at the rising edge, i.e. the value held over the clock just ended.
  int   as_low_cnt     = 0;
  int   done_cnt       = 0;
  int   err_cnt        = 0;
  int   br_fall_cnt    = 0;
  int   bgack_rise_cnt = 0;
  logic prev_br        = 1'b1;
  logic prev_bgack     = 1'b1;

  always @(posedge clk) begin
    if (!as_n) as_low_cnt = as_low_cnt + 1;
    if (done)  done_cnt = done_cnt + 1;
    if (err)   err_cnt = err_cnt + 1;
    if (prev_br && !br_n) br_fall_cnt = br_fall_cnt + 1;
    if (!prev_bgack && bgack_n) bgack_rise_cnt = bgack_rise_cnt + 1;
    prev_br    = br_n;
    prev_bgack = bgack_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_strobe(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!as_n) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_strb_seen"}, 32'(found), 32'd1);
  endtask

  task automatic start_req(input logic rw_i, input logic [22:0] a, input logic [1:0] be,
                           input logic [15:0] wd);
    req       = 1'b1;
    req_rw    = rw_i;
    req_addr  = a;
    req_be    = be;
    req_wdata = wd;
  endtask

  int snap_as, snap_done, snap_err, snap_br, snap_bgack;
  int tmo_at;

  initial begin
    por_n      = 1'b0;
    req        = 1'b0;
    req_rw     = 1'b1;
    req_addr   = '0;
    req_be     = 2'b11;
    req_wdata  = '0;
    bg_n       = 1'b1;
    bgack_in_n = 1'b1;
    as_in_n    = 1'b1;
    data_in    = '0;
    dtack_n    = 1'b1;
    berr_n     = 1'b1;

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_br_n",    32'(br_n), 32'd1);
    check("rst_bgack_n", 32'(bgack_n), 32'd1);
    check("rst_strobes", {29'd0, as_n, uds_n, lds_n}, 32'h7);
    check("rst_rw",      32'(rw), 32'd1);
    check("rst_oe",      {30'd0, bus_oe, data_oe}, 32'h0);
    check("rst_pulses",  {30'd0, done, err}, 32'h0);
    check("rst_rdata",   32'(rdata), 32'h0);
    check("rst_addr",    32'(addr_out), 32'h0);
    check("rst_wdata",   32'(data_out), 32'h0);
    por_n = 1'b1;
    @(negedge clk);

    // ---------------- read with late grant ----------------
    snap_as = as_low_cnt;
    start_req(1'b1, 23'h000100, 2'b11, 16'h0000);
    data_in = 16'hBEEF;
    repeat (3) @(negedge clk);
    check("rd_req_br_n",   32'(br_n), 32'd0);
    check("rd_req_bus_oe", 32'(bus_oe), 32'd0);
    bg_n = 1'b0;
    wait_strobe("rd");
    check("rd_strb_lanes", {30'd0, uds_n, lds_n}, 32'h0);
    check("rd_strb_rw",    32'(rw), 32'd1);
    repeat (3) @(negedge clk);
    dtack_n = 1'b0;
    @(negedge clk);
    check("rd_done",  32'(done), 32'd1);
    check("rd_err",   32'(err), 32'd0);
    check("rd_rdata", 32'(rdata), 32'hBEEF);
    check("rd_end_strobes", {29'd0, as_n, uds_n, lds_n}, 32'h7);
    req     = 1'b0;
    dtack_n = 1'b1;
    bg_n    = 1'b1;
    @(negedge clk);
    check("rd_rel_bus_oe",  32'(bus_oe), 32'd0);
    check("rd_rel_bgack_n", 32'(bgack_n), 32'd1);
    @(negedge clk);
    check("rd_as_low_clocks", 32'(as_low_cnt - snap_as), 32'd4);

    // ---------------- write, lower byte, grant held off by AS from another cycle ----------------
    start_req(1'b0, 23'h7A0000, 2'b01, 16'h1234);
    bg_n    = 1'b0;
    as_in_n = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_busy_br_n",   32'(br_n), 32'd0);
    check("wr_busy_bus_oe", 32'(bus_oe), 32'd0);
    as_in_n = 1'b1;
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (data_oe) begin
          found = 1'b1;
          break;
        end
      end
      check("wr_addr_seen", 32'(found), 32'd1);
    end
    check("wr_addr_out",   32'(addr_out), 32'h7A0000);
    check("wr_data_out",   32'(data_out), 32'h1234);
    check("wr_addr_rw",    32'(rw), 32'd0);
    check("wr_addr_as_n",  32'(as_n), 32'd1);
    @(negedge clk);
    check("wr_strb_as_n",  32'(as_n), 32'd0);
    check("wr_strb_lanes", {30'd0, uds_n, lds_n}, 32'h3);
    @(negedge clk);
    check("wr_wait_lanes", {30'd0, uds_n, lds_n}, 32'h2);
    check("wr_wait_doe",   32'(data_oe), 32'd1);
    dtack_n = 1'b0;
    @(negedge clk);
    check("wr_done",     32'(done), 32'd1);
    check("wr_end_doe",  32'(data_oe), 32'd1);
    check("wr_end_rw",   32'(rw), 32'd0);
    check("wr_end_as_n", 32'(as_n), 32'd1);
    req     = 1'b0;
    dtack_n = 1'b1;
    @(negedge clk);
    check("wr_rel_oe", {30'd0, bus_oe, data_oe}, 32'h0);
    @(negedge clk);

    // ---------------- bus error and DTACK together ----------------
    snap_done = done_cnt;
    start_req(1'b1, 23'h000300, 2'b10, 16'h0000);
    data_in = 16'h5555;
    wait_strobe("be");
    check("be_strb_lanes", {30'd0, uds_n, lds_n}, 32'h1);
    @(negedge clk);
    dtack_n = 1'b0;
    berr_n  = 1'b0;
    @(negedge clk);
    check("be_err",   32'(err), 32'd1);
    check("be_done",  32'(done), 32'd0);
    check("be_rdata", 32'(rdata), 32'hBEEF);
    req     = 1'b0;
    dtack_n = 1'b1;
    berr_n  = 1'b1;
    repeat (2) @(negedge clk);
    check("be_no_done", 32'(done_cnt - snap_done), 32'd0);

    // ---------------- timeout: err 4 clocks after WAIT entry ----------------
    start_req(1'b1, 23'h000400, 2'b11, 16'h0000);
    wait_strobe("to");
    tmo_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (err) begin
        tmo_at = i;
        break;
      end
    end
    // STRB clock, then 4 WAIT clocks, then END
    check("to_err_offset", 32'(tmo_at), 32'd5);
    check("to_strobes",    {29'd0, as_n, uds_n, lds_n}, 32'h7);
    check("to_done",       32'(done), 32'd0);
    check("to_rdata",      32'(rdata), 32'hBEEF);
    req = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- two back-to-back reads keep the bus ----------------
    snap_br    = br_fall_cnt;
    snap_bgack = bgack_rise_cnt;
    snap_done  = done_cnt;
    start_req(1'b1, 23'h000200, 2'b01, 16'h0000);
    data_in = 16'hA5C3;
    wait_strobe("kb1");
    @(negedge clk);
    dtack_n = 1'b0;
    @(negedge clk);
    check("kb1_done",  32'(done), 32'd1);
    check("kb1_rdata", 32'(rdata), 32'hA5C3);
    start_req(1'b1, 23'h000201, 2'b11, 16'h0000);
    data_in = 16'h0F0F;
    dtack_n = 1'b1;
    bg_n    = 1'b1;
    @(negedge clk);
    check("kb2_bgack_n", 32'(bgack_n), 32'd0);
    check("kb2_bus_oe",  32'(bus_oe), 32'd1);
    check("kb2_addr",    32'(addr_out), 32'h000201);
    wait_strobe("kb2");
    @(negedge clk);
    dtack_n = 1'b0;
    @(negedge clk);
    check("kb2_done",  32'(done), 32'd1);
    check("kb2_rdata", 32'(rdata), 32'h0F0F);
    req     = 1'b0;
    dtack_n = 1'b1;
    repeat (3) @(negedge clk);
    check("kb_br_asserts",  32'(br_fall_cnt - snap_br), 32'd1);
    check("kb_bgack_rises", 32'(bgack_rise_cnt - snap_bgack), 32'd1);
    check("kb_done_pulses", 32'(done_cnt - snap_done), 32'd2);

    // ---------------- reset in WAIT, then illegal byte enables ----------------
    bg_n = 1'b0;
    start_req(1'b1, 23'h000500, 2'b11, 16'h0000);
    wait_strobe("rs");
    @(negedge clk);
    check("rs_wait_as_n", 32'(as_n), 32'd0);
    por_n = 1'b0;
    #1;
    check("rs_strobes",  {29'd0, as_n, uds_n, lds_n}, 32'h7);
    check("rs_bus_oe",   32'(bus_oe), 32'd0);
    check("rs_bgack_n",  32'(bgack_n), 32'd1);
    check("rs_rdata",    32'(rdata), 32'h0);
    req  = 1'b0;
    bg_n = 1'b1;
    @(negedge clk);
    por_n = 1'b1;
    @(negedge clk);
    snap_err = err_cnt;
    start_req(1'b1, 23'h000600, 2'b00, 16'h0000);
    #1;
    check("ill_err",  32'(err), 32'd1);
    check("ill_br_n", 32'(br_n), 32'd1);
    @(negedge clk);
    check("ill_stay_br_n", 32'(br_n), 32'd1);
    check("ill_bus_oe",    32'(bus_oe), 32'd0);
    req    = 1'b0;
    req_be = 2'b11;
    @(negedge clk);
    check("ill_err_clear", 32'(err), 32'd0);
    check("ill_err_count", 32'(err_cnt - snap_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
